// File: rtl/demux_striping_n_if.sv
// Handshake bundle for demux_striping_n: one input word stream, LANES output lanes.
// master = source/consumer side, slave = the demux itself.
interface demux_striping_n_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4
);
    logic [DATA_W-1:0]       data_in;
    logic                    valid_in;
    logic                    ready_in;
    logic [LANES*DATA_W-1:0] data_out;
    logic [LANES-1:0]        valid_out;
    logic [LANES-1:0]        ready_out;

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out
    );
endinterface

// File: rtl/demux_striping_n.sv
// Round-robin striping demux: accepted words go to lane_sel's FWFT FIFO, then lane_sel advances.
// Optional accepted-word counter on port word_count when DEMUX_STRIPE_COUNT_EN is defined.
module demux_striping_n #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_2f,
    input  logic                       reset,
    input  logic                       resync,
    demux_striping_n_if.slave          bus,
    output logic [$clog2(LANES)-1:0]   lane_sel
`ifdef DEMUX_STRIPE_COUNT_EN
    ,
    output logic [15:0]                word_count
`endif
);
    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [LANES-1:0]        full;
    logic [LANES-1:0]        empty;
    logic [LANES-1:0]        push;
    logic [LANES-1:0]        pop;
    logic [LANES*DATA_W-1:0] data_out_w;
    logic                    ready_in_w;
    logic                    accept;

    // Head-of-line: only the selected lane's fullness gates the input.
    assign ready_in_w    = !full[lane_sel];
    assign accept        = bus.valid_in && ready_in_w;
    assign bus.ready_in  = ready_in_w;
    assign bus.data_out  = data_out_w;
    assign bus.valid_out = ~empty;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW:0]       wr_ptr;
        logic [AW:0]       rd_ptr;

        assign empty[g] = (wr_ptr == rd_ptr);
        assign full[g]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign push[g]  = accept && (lane_sel == LW'(g));
        assign pop[g]   = !empty[g] && bus.ready_out[g];
        assign data_out_w[g*DATA_W +: DATA_W] = mem[rd_ptr[AW-1:0]];

        always_ff @(posedge clk_2f or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    mem[k] <= '0;
                end
            end else begin
                if (push[g]) begin
                    mem[wr_ptr[AW-1:0]] <= bus.data_in;
                    wr_ptr              <= wr_ptr + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // resync wins over the advance; the word of that cycle already went to the old lane.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            lane_sel <= '0;
        end else if (resync) begin
            lane_sel <= '0;
        end else if (accept) begin
            if (lane_sel == LW'(LANES - 1)) begin
                lane_sel <= '0;
            end else begin
                lane_sel <= lane_sel + 1'b1;
            end
        end
    end

`ifdef DEMUX_STRIPE_COUNT_EN
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (accept) begin
            word_count <= word_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_striping_n.sv
// Self-checking bench for demux_striping_n (LANES=4, DEPTH=4, DATA_W=32).
// Per-lane queue scoreboard plus a table of stimulus/expected-lane records.
module tb_demux_striping_n;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DEPTH  = 4;

    logic        clk_2f = 1'b0;
    logic        reset  = 1'b1;
    logic        resync = 1'b0;
    logic [1:0]  lane_sel;
`ifdef DEMUX_STRIPE_COUNT_EN
    logic [15:0] word_count;
    int unsigned m_count;
`endif

    demux_striping_n_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    demux_striping_n #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .resync     (resync),
        .bus        (bus),
        .lane_sel   (lane_sel)
`ifdef DEMUX_STRIPE_COUNT_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 clk_2f = ~clk_2f;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] exp_q [LANES][$];
    int unsigned m_lane = 0;
    bit          last_acc = 0;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        rsync;
        int          dest;
        int          lane;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LANES; i++) exp_q[i].delete();
        m_lane = 0;
`ifdef DEMUX_STRIPE_COUNT_EN
        m_count = 0;
`endif
    endtask

    task automatic check_outputs();
        chk("ready_in", 64'(bus.ready_in), 64'(exp_q[m_lane].size() < DEPTH));
        chk("lane_sel", 64'(lane_sel), 64'(m_lane));
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("valid_out[%0d]", i), 64'(bus.valid_out[i]), 64'(exp_q[i].size() > 0));
            if (exp_q[i].size() > 0)
                chk($sformatf("data_out[%0d]", i), 64'(bus.data_out[i*DATA_W +: DATA_W]), 64'(exp_q[i][0]));
        end
`ifdef DEMUX_STRIPE_COUNT_EN
        chk("word_count", 64'(word_count), 64'(m_count[15:0]));
`endif
    endtask

    // One clock: update the model from the held inputs at the edge, check at the falling edge.
    task automatic cycle();
        bit acc;
        @(posedge clk_2f);
        acc = bus.valid_in && (exp_q[m_lane].size() < DEPTH);
        last_acc = acc;
        for (int i = 0; i < LANES; i++)
            if (bus.ready_out[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
        if (acc) begin
            exp_q[m_lane].push_back(bus.data_in);
`ifdef DEMUX_STRIPE_COUNT_EN
            m_count++;
`endif
        end
        if (resync) m_lane = 0;
        else if (acc) m_lane = (m_lane == LANES - 1) ? 0 : m_lane + 1;
        @(negedge clk_2f);
        check_outputs();
    endtask

    initial begin
        int unsigned n_acc;
        logic [31:0] w;

        tbl[0]  = '{32'hA0, 1'b1, 1'b0, 0, 1};
        tbl[1]  = '{32'hA1, 1'b1, 1'b0, 1, 2};
        tbl[2]  = '{32'hA2, 1'b1, 1'b0, 2, 3};
        tbl[3]  = '{32'hA3, 1'b1, 1'b0, 3, 0};
        tbl[4]  = '{32'hA4, 1'b1, 1'b0, 0, 1};
        tbl[5]  = '{32'hA5, 1'b1, 1'b0, 1, 2};
        tbl[6]  = '{32'hA6, 1'b1, 1'b0, 2, 3};
        tbl[7]  = '{32'hA7, 1'b1, 1'b0, 3, 0};
        tbl[8]  = '{32'h11, 1'b1, 1'b0, 0, 1};
        tbl[9]  = '{32'h00, 1'b0, 1'b0, -1, 1};
        tbl[10] = '{32'h00, 1'b0, 1'b0, -1, 1};
        tbl[11] = '{32'h22, 1'b1, 1'b0, 1, 2};
        tbl[12] = '{32'h55, 1'b1, 1'b1, 2, 0};
        tbl[13] = '{32'h66, 1'b1, 1'b0, 0, 1};
        tbl[14] = '{32'h00, 1'b0, 1'b1, -1, 0};
        tbl[15] = '{32'h77, 1'b1, 1'b0, 0, 1};

        bus.data_in   = '0;
        bus.valid_in  = 1'b0;
        bus.ready_out = '0;
        model_clear();

        // Reset state while reset is held
        repeat (2) @(negedge clk_2f);
        chk("rst_valid_out", 64'(bus.valid_out), 64'(0));
        chk("rst_data_out", 64'(bus.data_out[63:0]), 64'(0));
        chk("rst_data_out_hi", 64'(bus.data_out[127:64]), 64'(0));
        chk("rst_lane_sel", 64'(lane_sel), 64'(0));
        chk("rst_ready_in", 64'(bus.ready_in), 64'(1));
        reset = 1'b0;

        // Table: stream, gaps, resync with and without accept
        bus.ready_out = 4'b1111;
        for (int unsigned v = 0; v < 16; v++) begin
            bus.data_in  = tbl[v].data;
            bus.valid_in = tbl[v].valid;
            resync       = tbl[v].rsync;
            cycle();
            chk($sformatf("tbl%0d_lane_sel", v), 64'(lane_sel), 64'(tbl[v].lane));
            if (tbl[v].dest >= 0) begin
                chk($sformatf("tbl%0d_dest_valid", v), 64'(bus.valid_out[tbl[v].dest]), 64'(1));
                chk($sformatf("tbl%0d_dest_data", v),
                    64'(bus.data_out[tbl[v].dest*DATA_W +: DATA_W]), 64'(tbl[v].data));
            end
        end
        bus.valid_in = 1'b0;
        resync       = 1'b0;
        cycle();

        // Backpressure on lane 1; lane_sel is 1 here
        bus.ready_out = 4'b1101;
        w = 32'h100;
        n_acc = 0;
        for (int unsigned c = 0; c < 40; c++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = w;
            cycle();
            if (last_acc) begin w++; n_acc++; end
        end
        chk("bp_accepted_before_stall", 64'(n_acc), 64'(16));
        chk("bp_stall_ready_in", 64'(bus.ready_in), 64'(0));
        chk("bp_stall_lane_sel", 64'(lane_sel), 64'(1));
        bus.ready_out = 4'b1111;
        cycle();
        if (last_acc) begin w++; n_acc++; end
        chk("bp_pop_edge_lane_hold", 64'(lane_sel), 64'(1));
        bus.ready_out = 4'b1101;
        for (int unsigned c = 0; c < 12; c++) begin
            bus.data_in = w;
            cycle();
            if (last_acc) begin w++; n_acc++; end
        end
        chk("bp_total_accepted", 64'(n_acc), 64'(20));
        chk("bp_restall_lane_sel", 64'(lane_sel), 64'(1));
        bus.valid_in  = 1'b0;
        bus.ready_out = 4'b1111;
        repeat (8) cycle();
        chk("bp_drained", 64'(bus.valid_out), 64'(0));

        // Reset mid-stream with lanes 0..2 occupied
        resync = 1'b1;
        cycle();
        resync        = 1'b0;
        bus.ready_out = 4'b0000;
        for (int unsigned k = 0; k < 3; k++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 32'hC0 + k;
            cycle();
        end
        bus.valid_in = 1'b0;
        chk("pre_rst_valid_out", 64'(bus.valid_out), 64'(4'b0111));
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid_out", 64'(bus.valid_out), 64'(0));
        chk("async_rst_data_out", 64'(bus.data_out[127:64]), 64'(0));
        chk("async_rst_data_out_lo", 64'(bus.data_out[63:0]), 64'(0));
        chk("async_rst_lane_sel", 64'(lane_sel), 64'(0));
        chk("async_rst_ready_in", 64'(bus.ready_in), 64'(1));
        model_clear();
        @(negedge clk_2f);
        reset         = 1'b0;
        bus.ready_out = 4'b1111;
        bus.valid_in  = 1'b1;
        bus.data_in   = 32'hBEEF;
        cycle();
        bus.valid_in = 1'b0;
        chk("post_rst_lane0_valid", 64'(bus.valid_out), 64'(4'b0001));
        chk("post_rst_lane0_data", 64'(bus.data_out[31:0]), 64'(32'hBEEF));
        cycle();

`ifdef DEMUX_STRIPE_COUNT_EN
        // Counter wrap: 65537 accepted words since reset, one resync in between
        @(negedge clk_2f);
        reset = 1'b1;
        model_clear();
        @(negedge clk_2f);
        reset = 1'b0;
        bus.ready_out = 4'b1111;
        for (int unsigned i = 0; i < 65537; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 32'(i);
            resync       = (i == 30000);
            cycle();
        end
        bus.valid_in = 1'b0;
        resync       = 1'b0;
        chk("word_count_wrap", 64'(word_count), 64'(1));
        resync = 1'b1;
        cycle();
        resync = 1'b0;
        chk("word_count_resync_hold", 64'(word_count), 64'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
